// File: rtl/bcd_to_bin_converter.sv
// Purpose : packed multi-digit BCD word -> unsigned binary, one digit per clock, MSD first.
// Latency : out_valid rises DIGITS clocks after the accepting edge; one word per DIGITS+2 clocks.
// Backpressure: in_ready is high only in IDLE; a result is held in DONE until out_ready.
// Optional: define BCD_CHECK_EN to add the err output (any captured digit > 9).
module bcd_to_bin_converter #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out
`ifdef BCD_CHECK_EN
  ,
  output logic                  err
`endif
);

  localparam int CNT_W = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [BIN_W-1:0]    acc_q;
  logic [BIN_W-1:0]    acc_d;
  logic [4*DIGITS-1:0] shift_q;
  logic [CNT_W-1:0]    count_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [BIN_W-1:0]    bin_q;
  logic [3:0]          top_digit;

`ifdef BCD_CHECK_EN
  logic                err_q;
  logic                err_acc_q;
  logic                err_acc_d;
`endif

  // Next accumulator value: acc*10 + current most-significant digit, modulo 2^BIN_W.
  always_comb begin
    top_digit = shift_q[4*DIGITS-1 -: 4];
    acc_d     = (acc_q << 3) + (acc_q << 1) + BIN_W'(top_digit);
`ifdef BCD_CHECK_EN
    err_acc_d = err_acc_q | (top_digit > 4'd9);
`endif
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      shift_q     <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bin_q       <= '0;
`ifdef BCD_CHECK_EN
      err_q       <= 1'b0;
      err_acc_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shift_q    <= bcd_in;
            acc_q      <= '0;
            count_q    <= CNT_W'(DIGITS);
            in_ready_q <= 1'b0;
            state_q    <= CONV;
`ifdef BCD_CHECK_EN
            err_q      <= 1'b0;
            err_acc_q  <= 1'b0;
`endif
          end
        end
        CONV: begin
          acc_q   <= acc_d;
          shift_q <= shift_q << 4;
          count_q <= count_q - CNT_W'(1);
`ifdef BCD_CHECK_EN
          err_acc_q <= err_acc_d;
`endif
          if (count_q == CNT_W'(1)) begin
            bin_q       <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef BCD_CHECK_EN
            err_q       <= err_acc_d;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bin_out   = bin_q;
`ifdef BCD_CHECK_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// Scoreboard bench for bcd_to_bin_converter (DIGITS=4, BIN_W=14).
// Expected values come from a positional-weight model of the BCD word.
module tb_bcd_to_bin_converter;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd_in = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [BIN_W-1:0]    bin_out;
`ifdef BCD_CHECK_EN
  logic                err;
`endif

  bcd_to_bin_converter #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out)
`ifdef BCD_CHECK_EN
    ,
    .err       (err)
`endif
  );

  typedef struct {
    logic [BIN_W-1:0] val;
    logic             e;
    int               acc_edge;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   ordy_mode = 0;  // 0: low, 1: high, 2: random

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Value = sum of digit * 10^position, reduced modulo 2^BIN_W.
  function automatic exp_t model(input logic [4*DIGITS-1:0] w);
    exp_t        r;
    longint      v = 0;
    longint      p = 1;
    logic [63:0] vv;
    r.e = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      v = v + longint'(w[4*i +: 4]) * p;
      p = p * 10;
      if (w[4*i +: 4] > 4'd9) r.e = 1'b1;
    end
    vv = 64'(v);
    r.val = vv[BIN_W-1:0];
    r.acc_edge = 0;
    return r;
  endfunction

  // out_ready driver
  initial forever begin
    @(posedge clk);
    #1;
    case (ordy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: latency on each rising out_valid, value on every valid cycle, pop on handshake.
  initial begin
    bit prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (out_valid && sb.size() == 0) begin
          fail_now("unexpected_result");
        end else if (out_valid) begin
          if (!prev) chk("latency", cyc - sb[0].acc_edge, DIGITS);
          chk("bin_out", 32'(bin_out), 32'(sb[0].val));
`ifdef BCD_CHECK_EN
          chk("err", 32'(err), 32'(sb[0].e));
`endif
          if (out_ready) void'(sb.pop_front());
        end
        prev = out_valid;
      end
    end
  end

  task automatic send(input logic [4*DIGITS-1:0] w, input bit hold_valid, output int acc_edge);
    exp_t e;
    int   t = 0;
    bcd_in   = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
      acc_edge = -1;
      return;
    end
    e = model(w);
    e.acc_edge = cyc + 1;
    acc_edge = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!hold_valid) in_valid = 1'b0;
    bcd_in = (4*DIGITS)'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      fail_now("drain_timeout");
      sb.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_bin_out"}, 32'(bin_out), 0);
`ifdef BCD_CHECK_EN
    chk({tag, "_err"}, 32'(err), 0);
`endif
  endtask

  initial begin
    int e1, e2, e3, t;
    logic [4*DIGITS-1:0] w;
    logic [4*DIGITS-1:0] dir_words [4];
    dir_words[0] = 16'h1234;
    dir_words[1] = 16'h9999;
    dir_words[2] = 16'h0000;
    dir_words[3] = 16'h0001;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ordy_mode = 1;
    @(posedge clk);
    #2;

    // Directed words
    foreach (dir_words[i]) begin
      send(dir_words[i], 1'b0, e1);
      drain();
    end

    // Stalled output, ignored input while busy
    ordy_mode = 0;
    @(posedge clk);
    #2;
    send(16'h0042, 1'b0, e1);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) fail_now("stall_out_valid_timeout");
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_out_valid", 32'(out_valid), 1);
    end
    in_valid = 1'b1;
    bcd_in   = 16'h5555;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("busy_in_ready", 32'(in_ready), 0);
    ordy_mode = 1;
    drain();
    send(16'h0321, 1'b0, e1);
    drain();

    // Reset during the second CONV cycle
    send(16'h8765, 1'b0, e1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midconv_reset");
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(16'h0100, 1'b0, e1);
    drain();

    // Non-BCD digit then a clean word
    send(16'h12A4, 1'b0, e1);
    drain();
    send(16'h0007, 1'b0, e1);
    drain();

    // Back-to-back throughput with valid and ready held high
    send(16'h0001, 1'b1, e1);
    send(16'h0002, 1'b1, e2);
    send(16'h0003, 1'b0, e3);
    chk("spacing_1_2", e2 - e1, DIGITS + 2);
    chk("spacing_2_3", e3 - e2, DIGITS + 2);
    drain();

    // Randomized words with random backpressure (includes non-BCD digits and wrap)
    ordy_mode = 2;
    repeat (40) begin
      for (int d = 0; d < DIGITS; d++) begin
        if ($urandom_range(0, 7) == 0) w[4*d +: 4] = 4'($urandom_range(10, 15));
        else                           w[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      send(w, 1'b0, e1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #2;
    end
    ordy_mode = 1;
    drain();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
